// File: rtl/mem_write_checker.sv
// Self-check monitor on the core's data-memory write port: matches stores against an expected table.
// Latency: 1 cycle from sampled store strobe to registered match_cnt/pass/fail/done.
// Backpressure: none; passive observer, every store seen in RUN is evaluated on its edge.
//
// Ports:
//   clk        core clock (divided run clock)
//   rst        asynchronous active-low reset
//   en         arm/hold, level-sensitive; low aborts a run and clears the flags
//   memwrite   store strobe; dataadr / writedata are the store address / data
//   done       pass | fail
//   pass       every expected entry has been matched
//   fail       data mismatch on an expected address, or timeout
//   timeout    the fail was caused by the cycle limit
//   match_cnt  entries matched so far
//   err_addr   address of the failing store (0 on timeout)
//   err_data   data of the failing store (0 on timeout)
//
// Optional feature macro: WCHK_TIMEOUT_EN compiles in the RUN cycle counter and
// the timeout fail. Without it, RUN waits indefinitely and timeout stays 0.
module mem_write_checker #(
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter int                          NUM_CHK  = 1,
  parameter logic [NUM_CHK*ADDR_W-1:0]   EXP_ADDR = (NUM_CHK*ADDR_W)'(84),
  parameter logic [NUM_CHK*DATA_W-1:0]   EXP_DATA = (NUM_CHK*DATA_W)'(7),
  parameter bit                          ORDERED  = 1'b1,
  parameter int unsigned                 TIMEOUT  = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           memwrite,
  input  logic [ADDR_W-1:0]              dataadr,
  input  logic [DATA_W-1:0]              writedata,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [$clog2(NUM_CHK+1)-1:0]   match_cnt,
  output logic [ADDR_W-1:0]              err_addr,
  output logic [DATA_W-1:0]              err_data
);

  localparam int            CW       = $clog2(NUM_CHK + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_CHK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t              state, state_n;
  logic [NUM_CHK-1:0]  mask, mask_n;
  logic [CW-1:0]       cnt_n;
  logic                pass_n, fail_n, to_n;
  logic [ADDR_W-1:0]   eaddr_n;
  logic [DATA_W-1:0]   edata_n;

  // Store evaluation against the table
  logic                hit;
  logic                bad;
  logic [NUM_CHK-1:0]  hit_mask;
  logic                tmo_hit;

`ifdef WCHK_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [31:0] cyc_cnt;

  // Counts RUN cycles only; restarts on arming and saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
    end else if (state == S_IDLE && en) begin
      cyc_cnt <= '0;
    end else if (state == S_RUN && cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign tmo_hit = (cyc_cnt >= TO_LAST);
`else
  // TIMEOUT has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
  assign tmo_hit = 1'b0;
`endif

  // Candidate entries: ordered mode looks only at entry match_cnt, unordered
  // mode at every entry not yet matched. A full match takes the lowest index;
  // an address-only match flags a mismatch (used only if nothing matched).
  always_comb begin
    hit      = 1'b0;
    bad      = 1'b0;
    hit_mask = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if ((ORDERED ? (CW'(i) == match_cnt) : !mask[i]) &&
          (dataadr == EXP_ADDR[i*ADDR_W +: ADDR_W])) begin
        if (writedata == EXP_DATA[i*DATA_W +: DATA_W]) begin
          if (!hit) begin
            hit         = 1'b1;
            hit_mask[i] = 1'b1;
          end
        end else begin
          bad = 1'b1;
        end
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    cnt_n   = match_cnt;
    mask_n  = mask;
    pass_n  = pass;
    fail_n  = fail;
    to_n    = timeout;
    eaddr_n = err_addr;
    edata_n = err_data;

    case (state)
      S_IDLE: begin
        // The edge that arms the checker only clears state; a store on it is not evaluated.
        if (en) begin
          state_n = S_RUN;
          cnt_n   = '0;
          mask_n  = '0;
          eaddr_n = '0;
          edata_n = '0;
        end
      end

      S_RUN: begin
        if (!en) begin
          // Abort wins over a simultaneous store.
          state_n = S_IDLE;
        end else begin
          if (memwrite && hit) begin
            if (match_cnt != CNT_FULL) begin
              cnt_n = match_cnt + 1'b1;
            end
            mask_n = mask | hit_mask;
            if (cnt_n == CNT_FULL) begin
              state_n = S_PASS;
              pass_n  = 1'b1;
            end
          end else if (memwrite && bad) begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
            eaddr_n = dataadr;
            edata_n = writedata;
          end
          // Timeout only fires if this edge did not already resolve the run,
          // so a final match on the same edge still passes.
          if (state_n == S_RUN && tmo_hit) begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
            to_n    = 1'b1;
            eaddr_n = '0;
            edata_n = '0;
          end
        end
      end

      S_PASS, S_FAIL: begin
        if (!en) begin
          state_n = S_IDLE;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          to_n    = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Without WCHK_TIMEOUT_EN, to_n is never set, so timeout holds 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      mask      <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      match_cnt <= cnt_n;
      mask      <= mask_n;
      pass      <= pass_n;
      fail      <= fail_n;
      done      <= pass_n | fail_n;
      timeout   <= to_n;
      err_addr  <= eaddr_n;
      err_data  <= edata_n;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: four instances (default table, 3-entry ordered,
// 3-entry unordered, 2-entry unordered with TIMEOUT=20) driven from one
// directed vector table plus hand-written reset / re-arm / timeout sequences.
module tb_mem_write_checker;

  logic        clk;
  logic        rst;
  logic        en_v  [4];
  logic        mw_v  [4];
  logic [31:0] adr_v [4];
  logic [31:0] dat_v [4];

  logic        done_v [4];
  logic        pass_v [4];
  logic        fail_v [4];
  logic        to_v   [4];
  logic [31:0] ea_v   [4];
  logic [31:0] ed_v   [4];
  logic [31:0] cnt_v  [4];

  logic        cnt_a;
  logic [1:0]  cnt_b, cnt_c, cnt_d;

  always_comb begin
    cnt_v[0] = 32'(cnt_a);
    cnt_v[1] = 32'(cnt_b);
    cnt_v[2] = 32'(cnt_c);
    cnt_v[3] = 32'(cnt_d);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_write_checker u_a (
    .clk(clk), .rst(rst), .en(en_v[0]), .memwrite(mw_v[0]),
    .dataadr(adr_v[0]), .writedata(dat_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(to_v[0]),
    .match_cnt(cnt_a), .err_addr(ea_v[0]), .err_data(ed_v[0])
  );

  mem_write_checker #(
    .NUM_CHK(3), .ORDERED(1'b1),
    .EXP_ADDR({32'h18, 32'h14, 32'h10}), .EXP_DATA({32'd3, 32'd2, 32'd1})
  ) u_b (
    .clk(clk), .rst(rst), .en(en_v[1]), .memwrite(mw_v[1]),
    .dataadr(adr_v[1]), .writedata(dat_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(to_v[1]),
    .match_cnt(cnt_b), .err_addr(ea_v[1]), .err_data(ed_v[1])
  );

  mem_write_checker #(
    .NUM_CHK(3), .ORDERED(1'b0),
    .EXP_ADDR({32'h18, 32'h14, 32'h10}), .EXP_DATA({32'd3, 32'd2, 32'd1})
  ) u_c (
    .clk(clk), .rst(rst), .en(en_v[2]), .memwrite(mw_v[2]),
    .dataadr(adr_v[2]), .writedata(dat_v[2]),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(to_v[2]),
    .match_cnt(cnt_c), .err_addr(ea_v[2]), .err_data(ed_v[2])
  );

  mem_write_checker #(
    .NUM_CHK(2), .ORDERED(1'b0), .TIMEOUT(20),
    .EXP_ADDR({32'h24, 32'h20}), .EXP_DATA({32'hB, 32'hA})
  ) u_d (
    .clk(clk), .rst(rst), .en(en_v[3]), .memwrite(mw_v[3]),
    .dataadr(adr_v[3]), .writedata(dat_v[3]),
    .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]), .timeout(to_v[3]),
    .match_cnt(cnt_d), .err_addr(ea_v[3]), .err_data(ed_v[3])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic en, input logic mw,
                       input logic [31:0] adr, input logic [31:0] dat);
    en_v[d]  = en;
    mw_v[d]  = mw;
    adr_v[d] = adr;
    dat_v[d] = dat;
  endtask

  typedef struct {
    int          dut;
    logic        en;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        pass;
    logic        fail;
    logic        ck;     // compare match_cnt / err_* too
    int          cnt;
    logic [31:0] eaddr;
    logic [31:0] edata;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int dut, logic en, logic mw, logic [31:0] adr, logic [31:0] dat,
                              logic p, logic f, logic ck, int cnt,
                              logic [31:0] ea, logic [31:0] ed, string name);
    vec_t v;
    v.dut = dut; v.en = en; v.mw = mw; v.adr = adr; v.dat = dat;
    v.pass = p; v.fail = f; v.ck = ck; v.cnt = cnt;
    v.eaddr = ea; v.edata = ed; v.name = name;
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);

    //               dut en mw adr    dat  pass fail ck cnt ea    ed
    // Default table (84,7)
    vq.push_back(mk(0, 1, 0, 32'd0,  32'd0, 0, 0, 1, 0, 0,     0, "a_arm"));
    vq.push_back(mk(0, 1, 1, 32'd80, 32'd7, 0, 0, 1, 0, 0,     0, "a_other_addr"));
    vq.push_back(mk(0, 1, 0, 32'd84, 32'd7, 0, 0, 1, 0, 0,     0, "a_no_strobe"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd7, 1, 0, 1, 1, 0,     0, "a_pass"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd9, 1, 0, 1, 1, 0,     0, "a_pass_sticky"));
    vq.push_back(mk(0, 0, 0, 32'd0,  32'd0, 0, 0, 0, 0, 0,     0, "a_pass_drop_en"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd7, 0, 0, 1, 0, 0,     0, "a_store_on_arm"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd8, 0, 1, 1, 0, 84,    8, "a_mismatch"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd7, 0, 1, 1, 0, 84,    8, "a_fail_sticky"));
    vq.push_back(mk(0, 0, 1, 32'd84, 32'd7, 0, 0, 0, 0, 0,     0, "a_fail_drop_en"));
    vq.push_back(mk(0, 1, 0, 32'd0,  32'd0, 0, 0, 1, 0, 0,     0, "a_rearm_clears"));
    vq.push_back(mk(0, 0, 1, 32'd84, 32'd7, 0, 0, 0, 0, 0,     0, "a_abort_wins"));
    vq.push_back(mk(0, 1, 0, 32'd0,  32'd0, 0, 0, 1, 0, 0,     0, "a_arm2"));
    vq.push_back(mk(0, 1, 1, 32'd84, 32'd7, 1, 0, 1, 1, 0,     0, "a_pass2"));
    // Ordered 3-entry table
    vq.push_back(mk(1, 1, 0, 32'h0,  32'd0, 0, 0, 1, 0, 0,     0, "b_arm"));
    vq.push_back(mk(1, 1, 1, 32'h14, 32'd2, 0, 0, 1, 0, 0,     0, "b_out_of_order"));
    vq.push_back(mk(1, 1, 1, 32'h10, 32'd1, 0, 0, 1, 1, 0,     0, "b_e0"));
    vq.push_back(mk(1, 1, 1, 32'h14, 32'd2, 0, 0, 1, 2, 0,     0, "b_e1"));
    vq.push_back(mk(1, 1, 0, 32'h18, 32'd3, 0, 0, 1, 2, 0,     0, "b_no_strobe"));
    vq.push_back(mk(1, 1, 1, 32'h18, 32'd3, 1, 0, 1, 3, 0,     0, "b_pass"));
    vq.push_back(mk(1, 0, 0, 32'h0,  32'd0, 0, 0, 0, 0, 0,     0, "b_drop_en"));
    vq.push_back(mk(1, 1, 0, 32'h0,  32'd0, 0, 0, 1, 0, 0,     0, "b_rearm"));
    vq.push_back(mk(1, 1, 1, 32'h10, 32'd1, 0, 0, 1, 1, 0,     0, "b_e0_again"));
    vq.push_back(mk(1, 1, 1, 32'h18, 32'd3, 0, 0, 1, 1, 0,     0, "b_later_entry_ignored"));
    vq.push_back(mk(1, 1, 1, 32'h14, 32'd5, 0, 1, 1, 1, 32'h14, 5, "b_mismatch"));
    vq.push_back(mk(1, 1, 1, 32'h14, 32'd2, 0, 1, 1, 1, 32'h14, 5, "b_fail_hold"));
    // Unordered 3-entry table
    vq.push_back(mk(2, 1, 0, 32'h0,  32'd0, 0, 0, 1, 0, 0,     0, "c_arm"));
    vq.push_back(mk(2, 1, 1, 32'h18, 32'd3, 0, 0, 1, 1, 0,     0, "c_e2"));
    vq.push_back(mk(2, 1, 1, 32'h10, 32'd1, 0, 0, 1, 2, 0,     0, "c_e0"));
    vq.push_back(mk(2, 1, 1, 32'h18, 32'd7, 0, 0, 1, 2, 0,     0, "c_matched_addr_ignored"));
    vq.push_back(mk(2, 1, 1, 32'h14, 32'd9, 0, 1, 1, 2, 32'h14, 9, "c_mismatch"));

    // Reset state
    #12;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_done%0d", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset_cnt%0d", d), cnt_v[d], 32'd0);
    end
    rst = 1'b1;
    step();

    foreach (vq[k]) begin
      drive(vq[k].dut, vq[k].en, vq[k].mw, vq[k].adr, vq[k].dat);
      step();
      check({vq[k].name, ".pass"}, 32'(pass_v[vq[k].dut]), 32'(vq[k].pass));
      check({vq[k].name, ".fail"}, 32'(fail_v[vq[k].dut]), 32'(vq[k].fail));
      check({vq[k].name, ".done"}, 32'(done_v[vq[k].dut]), 32'(vq[k].pass | vq[k].fail));
      if (vq[k].ck) begin
        check({vq[k].name, ".match_cnt"}, cnt_v[vq[k].dut], 32'(vq[k].cnt));
        check({vq[k].name, ".err_addr"}, ea_v[vq[k].dut], vq[k].eaddr);
        check({vq[k].name, ".err_data"}, ed_v[vq[k].dut], vq[k].edata);
      end
      drive(vq[k].dut, vq[k].en, 1'b0, 32'h0, 32'h0);
    end

    // Asynchronous reset mid-cycle with one entry matched
    drive(3, 1'b1, 1'b0, 32'h0, 32'h0);
    step();
    drive(3, 1'b1, 1'b1, 32'h20, 32'hA);
    step();
    drive(3, 1'b1, 1'b0, 32'h0, 32'h0);
    check("d_one_matched", cnt_v[3], 32'd1);
    #3 rst = 1'b0;
    #1;
    check("arst_cnt", cnt_v[3], 32'd0);
    check("arst_flags", {29'd0, done_v[3], pass_v[3], fail_v[3]}, 32'd0);
    check("arst_a_pass", 32'(pass_v[0]), 32'd0);
    check("arst_c_fail", 32'(fail_v[2]), 32'd0);
    check("arst_c_err_addr", ea_v[2], 32'd0);
    #2 rst = 1'b1;

    // Re-arm (en held high) and complete the table out of order
    step();
    check("d_rearm_cnt", cnt_v[3], 32'd0);
    drive(3, 1'b1, 1'b1, 32'h24, 32'hB);
    step();
    check("d_e1_cnt", cnt_v[3], 32'd1);
    drive(3, 1'b1, 1'b1, 32'h20, 32'hA);
    step();
    drive(3, 1'b1, 1'b0, 32'h0, 32'h0);
    check("d_pass", 32'(pass_v[3]), 32'd1);
    check("d_pass_cnt", cnt_v[3], 32'd2);

    // Drop en in PASS, then a fresh run
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("d_idle_pass", 32'(pass_v[3]), 32'd0);
    check("d_idle_done", 32'(done_v[3]), 32'd0);
    drive(3, 1'b1, 1'b0, 32'h0, 32'h0);
    step();
    check("d_newrun_cnt", cnt_v[3], 32'd0);
    check("d_newrun_done", 32'(done_v[3]), 32'd0);

    // No stores after the RUN-entry edge above
    begin
      int early = 0;
      for (int c = 1; c < 20; c++) begin
        step();
        if (done_v[3]) early++;
      end
      check("to_not_before_20", 32'(early), 32'd0);
`ifdef WCHK_TIMEOUT_EN
      step();
      check("to_fail", 32'(fail_v[3]), 32'd1);
      check("to_flag", 32'(to_v[3]), 32'd1);
      check("to_pass", 32'(pass_v[3]), 32'd0);
      check("to_err_addr", ea_v[3], 32'd0);
      check("to_err_data", ed_v[3], 32'd0);
`else
      for (int c = 20; c <= 100; c++) begin
        step();
        if (done_v[3]) early++;
      end
      check("no_to_done", 32'(early), 32'd0);
      check("no_to_flag", 32'(to_v[3]), 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-check monitor on the data-memory write port of the MIPS core. It watches `memwrite`/`dataadr`/`writedata` and matches them against a parameter-supplied table of expected (address, data) stores, either in order or in any order. It raises sticky `pass`/`fail` flags with error capture, and has an optional cycle timeout. It generalises the single-store "address 84 = 7" success check to N stores, with mismatch detection, on-chip use, and a board-visible result.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `NUM_CHK`, 1, number of expected stores; legal range 1..16.
- `EXP_ADDR`, {84}, flattened `NUM_CHK*ADDR_W` vector; entry i is at bits [i*ADDR_W +: ADDR_W].
- `EXP_DATA`, {7}, flattened `NUM_CHK*DATA_W` vector, indexed the same way.
- `ORDERED`, 1, 1 = entries must be matched in index order; 0 = any order.
- `TIMEOUT`, 500, number of RUN cycles allowed before a timeout fail (used only with `WCHK_TIMEOUT_EN`).

Ports:
- `clk`  in  1  core clock (the divided run clock).
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  arm/hold; level-sensitive.
- `memwrite`  in  1  store strobe from the core.
- `dataadr`  in  ADDR_W  store address.
- `writedata`  in  DATA_W  store data.
- `done`  out  1  checker is in PASS or FAIL.
- `pass`  out  1  all entries matched.
- `fail`  out  1  data mismatch or timeout.
- `timeout`  out  1  the fail was caused by timeout.
- `match_cnt`  out  $clog2(NUM_CHK+1)  number of entries matched so far.
- `err_addr`  out  ADDR_W  address of the failing store (0 on timeout).
- `err_data`  out  DATA_W  data of the failing store (0 on timeout).

## Operation
- States: IDLE, RUN, PASS, FAIL. All outputs are registered.
- `rst`=0 (any time, including mid-RUN) -> IDLE. All outputs = 0, match mask = 0, cycle counter = 0.
- IDLE: when `en`=1, go to RUN and clear `match_cnt`, the mask, the cycle counter and the err registers.
- RUN with `en`=0: abort to IDLE. No flag is set.
- RUN sampling: each rising edge with `memwrite`=1 evaluates one store.
  - ORDERED=1: compare only against entry `match_cnt`.
    - Address and data equal -> `match_cnt`+1.
    - Address equal, data different -> FAIL; capture `err_addr`/`err_data`.
    - Any other address is ignored, including addresses of other entries.
  - ORDERED=0: consider all unmatched entries.
    - If any has equal address and data, set the mask bit of the lowest such index and `match_cnt`+1.
    - Else, if any unmatched entry has an equal address with different data -> FAIL with capture.
    - Stores to an already-matched address are ignored.
- RUN -> PASS on the edge where the matched count becomes NUM_CHK.
- PASS/FAIL are sticky while `en`=1. When `en`=0, go to IDLE; flags clear on that same edge.
- Arithmetic: `match_cnt` saturates at NUM_CHK. The cycle counter is 32-bit, saturating, and counts only in RUN.

## Timing
- A store sampled at edge k updates `match_cnt` and `pass`/`fail`/`done`, visible immediately after edge k. Latency is 1 cycle from strobe to flag.
- IDLE->RUN takes 1 edge. A store presented on the same edge that `en` first rises is not evaluated.
- Timeout: if still in RUN after the cycle counter reaches TIMEOUT-1, the next edge goes to FAIL with `timeout`=1.
- Simultaneous final match and timeout on the same edge -> PASS wins.
- Simultaneous `en` fall and store -> abort wins; the store is ignored.
- `done` = `pass` | `fail`. `pass` and `fail` are never 1 together.

## Configuration
- `WCHK_TIMEOUT_EN` defined: the cycle counter and timeout fail are compiled in.
- `WCHK_TIMEOUT_EN` undefined: no counter logic, `timeout` is tied to 0, and RUN waits indefinitely.

## Test plan
- Defaults, reset released, `en`=1, store (84,7) -> `pass`=1, `match_cnt`=1, `done`=1 one edge later. `fail`=0.
- NUM_CHK=3, ORDERED=1, table (0x10,1),(0x14,2),(0x18,3); stores (0x14,2),(0x10,1),(0x14,2),(0x18,3).
  - The first (0x14,2) is ignored; the sequence ends with `pass`=1 and `match_cnt`=3.
- Same table, ORDERED=0, stores (0x18,3),(0x10,1),(0x14,9) -> `fail`=1, `err_addr`=0x14, `err_data`=9, `match_cnt`=2.
- `WCHK_TIMEOUT_EN` defined, TIMEOUT=20, no stores -> `fail`=1 and `timeout`=1 exactly 20 edges after RUN entry. `err_addr`=0.
- Without the macro, the same stimulus for 100 cycles -> `done`=0.
- NUM_CHK=2 with 1 entry matched, pulse `rst`=0 asynchronously mid-cycle -> all outputs 0 immediately.
  - Re-arm, then a full store sequence -> `pass`=1.
- In PASS, drop `en` -> IDLE and `pass`=0 next edge. Raise `en` -> a new run with `match_cnt`=0.
